// File: rtl/uart16550_regs.sv
`default_nettype none
// ============================================================================
//  Module   : uart16550_regs
//  Purpose  : 16550-style UART with single-entry holding registers. Contains
//             the register file, baud generator, transmitter, receiver,
//             modem status and interrupt identification.
//  Ports    : clk, wb_rst_i (async, active-high)
//             wb_addr_i/wb_dat_i/wb_we_i/wb_re_i : 8-bit register port
//             wb_dat_o : registered read data
//             modem_inputs {cts,dsr,ri,dcd}, srx_pad_i : serial side inputs
//             stx_pad_o, rts_pad_o, dtr_pad_o, int_o : serial side outputs
//  Revision : 1.0 - initial release
// ============================================================================
module uart16550_regs (
    input  logic       clk,
    input  logic       wb_rst_i,
    input  logic [2:0] wb_addr_i,
    input  logic [7:0] wb_dat_i,
    output logic [7:0] wb_dat_o,
    input  logic       wb_we_i,
    input  logic       wb_re_i,
    input  logic [3:0] modem_inputs,
    output logic       stx_pad_o,
    input  logic       srx_pad_i,
    output logic       rts_pad_o,
    output logic       dtr_pad_o,
    output logic       int_o
);

    typedef enum logic [2:0] {
        TX_IDLE  = 3'd0,
        TX_START = 3'd1,
        TX_DATA  = 3'd2,
        TX_PAR   = 3'd3,
        TX_STOP  = 3'd4
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_PAR   = 3'd3,
        RX_STOP  = 3'd4
    } rx_state_t;

    localparam logic [3:0] c_IID_NONE = 4'b0001;
    localparam logic [3:0] c_IID_LS   = 4'b0110;
    localparam logic [3:0] c_IID_RX   = 4'b0100;
    localparam logic [3:0] c_IID_THR  = 4'b0010;
    localparam logic [3:0] c_IID_MS   = 4'b0000;

    // Register file
    logic [7:0] r_lcr, r_scr, r_dll, r_dlm, r_thr, r_rbr;
    logic [3:0] r_ier;
    logic [4:0] r_mcr;
    // Line / interrupt status
    logic       r_dr, r_oe, r_pe, r_fe, r_bi, r_thre, r_thre_d, r_thri, r_int;
    // Modem status: deltas {dDCD,TERI,dDSR,dCTS}, levels {DCD,RI,DSR,CTS}
    logic [3:0] r_msr_d, r_modem_prev, r_modem_m, r_modem_s;
    logic       r_rx_m, r_rx_s, r_rx_prev;
    logic [15:0] r_baud_cnt;
    // Transmitter
    tx_state_t  r_tx_state;
    logic [3:0] r_tx_tcnt;
    logic [2:0] r_tx_bcnt;
    logic [7:0] r_tx_shift;
    logic       r_tx_par, r_tx_line, r_tx_stop2;
    // Receiver
    rx_state_t  r_rx_state;
    logic [3:0] r_rx_tcnt;
    logic [2:0] r_rx_bcnt;
    logic [7:0] r_rx_shift;
    logic       r_rx_par, r_rx_pe, r_rx_zero;

    logic        w_dlab, w_loop;
    logic        w_wr_thr, w_wr_dll, w_wr_dlm, w_wr_ier, w_wr_fcr;
    logic        w_rd_rbr, w_rd_iir, w_rd_lsr, w_rd_msr;
    logic [15:0] w_divisor;
    logic        w_tick, w_tx_load, w_tx_par, w_temt, w_tx_int, w_rx_line;
    logic        w_rx_exp_par, w_rx_done;
    logic [2:0]  w_last_idx;
    logic [7:0]  w_mask, w_lsr, w_msr, w_iir, w_rd_data;
    logic [3:0]  w_modem_eff, w_modem_evt, w_iid;

    assign w_dlab   = r_lcr[7];
    assign w_loop   = r_mcr[4];
    assign w_wr_thr = wb_we_i && (wb_addr_i == 3'd0) && !w_dlab;
    assign w_wr_dll = wb_we_i && (wb_addr_i == 3'd0) &&  w_dlab;
    assign w_wr_dlm = wb_we_i && (wb_addr_i == 3'd1) &&  w_dlab;
    assign w_wr_ier = wb_we_i && (wb_addr_i == 3'd1) && !w_dlab;
    assign w_wr_fcr = wb_we_i && (wb_addr_i == 3'd2);
    assign w_rd_rbr = wb_re_i && (wb_addr_i == 3'd0) && !w_dlab;
    assign w_rd_iir = wb_re_i && (wb_addr_i == 3'd2);
    assign w_rd_lsr = wb_re_i && (wb_addr_i == 3'd5);
    assign w_rd_msr = wb_re_i && (wb_addr_i == 3'd6);

    // Word length 5..8 maps to last data-bit index 4..7
    assign w_last_idx = {1'b1, r_lcr[1:0]};
    assign w_mask     = 8'hFF >> (2'd3 - r_lcr[1:0]);

    // Stick parity sends the inverse of the even-select bit
    assign w_tx_par     = r_lcr[5] ? ~r_lcr[4] : (^(r_thr & w_mask)) ^ ~r_lcr[4];
    assign w_rx_exp_par = r_lcr[5] ? ~r_lcr[4] : r_rx_par ^ ~r_lcr[4];

    assign w_divisor = {r_dlm, r_dll};
    assign w_tick    = (w_divisor != 16'd0) && (r_baud_cnt == w_divisor - 16'd1);

    assign w_tx_int  = r_tx_line & ~r_lcr[6];
    assign w_rx_line = w_loop ? w_tx_int : r_rx_s;
    assign w_tx_load = (r_tx_state == TX_IDLE) && !r_thre && w_tick;
    assign w_temt    = r_thre && (r_tx_state == TX_IDLE);
    assign w_rx_done = w_tick && (r_rx_tcnt == 4'd7) && (r_rx_state == RX_STOP);

    // In loopback the modem levels come from {OUT2, OUT1, DTR, RTS}
    assign w_modem_eff = w_loop ? {r_mcr[3], r_mcr[2], r_mcr[0], r_mcr[1]}
                                : {r_modem_s[0], r_modem_s[1], r_modem_s[2], r_modem_s[3]};
    assign w_modem_evt = {w_modem_eff[3] ^ r_modem_prev[3],
                          r_modem_prev[2] & ~w_modem_eff[2],
                          w_modem_eff[1] ^ r_modem_prev[1],
                          w_modem_eff[0] ^ r_modem_prev[0]};

    assign w_lsr = {r_pe | r_fe | r_bi, w_temt, r_thre, r_bi, r_fe, r_pe, r_oe, r_dr};
    assign w_msr = {r_modem_prev, r_msr_d};
    assign w_iir = {4'hC, w_iid};

    always_comb begin
        w_iid = c_IID_NONE;
        if (r_ier[2] && (r_oe || r_pe || r_fe || r_bi)) w_iid = c_IID_LS;
        else if (r_ier[0] && r_dr)                      w_iid = c_IID_RX;
        else if (r_ier[1] && r_thri)                    w_iid = c_IID_THR;
        else if (r_ier[3] && (r_msr_d != 4'd0))         w_iid = c_IID_MS;
    end

    always_comb begin
        w_rd_data = 8'h00;
        case (wb_addr_i)
            3'd0: w_rd_data = w_dlab ? r_dll : r_rbr;
            3'd1: w_rd_data = w_dlab ? r_dlm : {4'h0, r_ier};
            3'd2: w_rd_data = w_iir;
            3'd3: w_rd_data = r_lcr;
            3'd4: w_rd_data = {3'b000, r_mcr};
            3'd5: w_rd_data = w_lsr;
            3'd6: w_rd_data = w_msr;
            default: w_rd_data = r_scr;
        endcase
    end

    assign stx_pad_o = w_loop ? 1'b1 : w_tx_int;
    assign rts_pad_o = ~w_loop & r_mcr[1];
    assign dtr_pad_o = ~w_loop & r_mcr[0];
    assign int_o     = r_int;

    // Register file, read port and baud counter
    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_lcr <= 8'h03; r_ier <= 4'h0; r_mcr <= 5'h00; r_scr <= 8'h00;
            r_dll <= 8'h00; r_dlm <= 8'h00; r_thr <= 8'h00;
            wb_dat_o <= 8'h00; r_baud_cnt <= 16'd0;
        end else begin
            if (wb_we_i) begin
                case (wb_addr_i)
                    3'd0: if (w_dlab) r_dll <= wb_dat_i; else r_thr <= wb_dat_i;
                    3'd1: if (w_dlab) r_dlm <= wb_dat_i; else r_ier <= wb_dat_i[3:0];
                    3'd3: r_lcr <= wb_dat_i;
                    3'd4: r_mcr <= wb_dat_i[4:0];
                    3'd7: r_scr <= wb_dat_i;
                    default: ;
                endcase
            end
            if (wb_re_i) wb_dat_o <= w_rd_data;
            if (w_wr_dll || w_wr_dlm || (w_divisor == 16'd0) || w_tick)
                r_baud_cnt <= 16'd0;
            else
                r_baud_cnt <= r_baud_cnt + 16'd1;
        end
    end

    // Status bits: clearing reads are applied first so that a status event
    // in the same cycle overrides them.
    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_dr <= 1'b0; r_oe <= 1'b0; r_pe <= 1'b0; r_fe <= 1'b0; r_bi <= 1'b0;
            r_thre <= 1'b1; r_thre_d <= 1'b1; r_thri <= 1'b0; r_int <= 1'b0;
            r_rbr <= 8'h00; r_msr_d <= 4'h0; r_modem_prev <= 4'h0;
        end else begin
            if (w_wr_thr)                         r_thre <= 1'b0;
            else if (w_tx_load || (w_wr_fcr && wb_dat_i[2])) r_thre <= 1'b1;
            r_thre_d <= r_thre;

            if (w_rd_iir && (w_iid == c_IID_THR)) r_thri <= 1'b0;
            if ((r_thre && !r_thre_d) || (w_wr_ier && wb_dat_i[1] && !r_ier[1] && r_thre))
                r_thri <= 1'b1;
            if (w_wr_thr)                         r_thri <= 1'b0;

            if (w_rd_rbr || (w_wr_fcr && wb_dat_i[1])) r_dr <= 1'b0;
            if (w_wr_fcr && wb_dat_i[1])          r_rbr <= 8'h00;
            if (w_rd_lsr) begin
                r_oe <= 1'b0; r_pe <= 1'b0; r_fe <= 1'b0; r_bi <= 1'b0;
            end
            if (w_rx_done) begin
                r_rbr <= r_rx_shift;
                r_dr  <= 1'b1;
                if (r_dr)                     r_oe <= 1'b1;
                if (r_rx_pe)                  r_pe <= 1'b1;
                if (!w_rx_line)               r_fe <= 1'b1;
                if (r_rx_zero && !w_rx_line)  r_bi <= 1'b1;
            end

            r_msr_d      <= (w_rd_msr ? 4'h0 : r_msr_d) | w_modem_evt;
            r_modem_prev <= w_modem_eff;
            r_int        <= ~w_iid[0];
        end
    end

    // Input synchronisers and rx edge history
    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_modem_m <= 4'h0; r_modem_s <= 4'h0;
            r_rx_m <= 1'b1; r_rx_s <= 1'b1; r_rx_prev <= 1'b1;
        end else begin
            r_modem_m <= modem_inputs; r_modem_s <= r_modem_m;
            r_rx_m <= srx_pad_i; r_rx_s <= r_rx_m; r_rx_prev <= w_rx_line;
        end
    end

    // Transmitter: each bit is held for 16 baud ticks
    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_tx_state <= TX_IDLE; r_tx_tcnt <= 4'd0; r_tx_bcnt <= 3'd0;
            r_tx_shift <= 8'h00; r_tx_par <= 1'b0; r_tx_line <= 1'b1; r_tx_stop2 <= 1'b0;
        end else if (r_tx_state == TX_IDLE) begin
            r_tx_line <= 1'b1;
            if (w_tx_load) begin
                r_tx_shift <= r_thr;
                r_tx_par   <= w_tx_par;
                r_tx_state <= TX_START;
                r_tx_line  <= 1'b0;
                r_tx_tcnt  <= 4'd0;
                r_tx_bcnt  <= 3'd0;
                r_tx_stop2 <= 1'b0;
            end
        end else if (w_tick) begin
            r_tx_tcnt <= r_tx_tcnt + 4'd1;
            if (r_tx_tcnt == 4'd15) begin
                case (r_tx_state)
                    TX_START: begin
                        r_tx_line  <= r_tx_shift[0];
                        r_tx_shift <= r_tx_shift >> 1;
                        r_tx_state <= TX_DATA;
                    end
                    TX_DATA: begin
                        if (r_tx_bcnt == w_last_idx) begin
                            r_tx_line  <= r_lcr[3] ? r_tx_par : 1'b1;
                            r_tx_state <= r_lcr[3] ? TX_PAR : TX_STOP;
                        end else begin
                            r_tx_line  <= r_tx_shift[0];
                            r_tx_shift <= r_tx_shift >> 1;
                            r_tx_bcnt  <= r_tx_bcnt + 3'd1;
                        end
                    end
                    TX_PAR: begin
                        r_tx_line  <= 1'b1;
                        r_tx_state <= TX_STOP;
                    end
                    default: begin
                        if (r_lcr[2] && !r_tx_stop2) r_tx_stop2 <= 1'b1;
                        else                         r_tx_state <= TX_IDLE;
                    end
                endcase
            end
        end
    end

    // Receiver: samples at tick 7 of each 16-tick bit (the 8th tick),
    // advances on tick 15. The stop-bit sample completes the frame early
    // so the next start edge can be caught.
    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_rx_state <= RX_IDLE; r_rx_tcnt <= 4'd0; r_rx_bcnt <= 3'd0;
            r_rx_shift <= 8'h00; r_rx_par <= 1'b0; r_rx_pe <= 1'b0; r_rx_zero <= 1'b1;
        end else if (r_rx_state == RX_IDLE) begin
            if (!w_rx_line && r_rx_prev) begin
                r_rx_state <= RX_START;
                r_rx_tcnt  <= 4'd0;
                r_rx_bcnt  <= 3'd0;
                r_rx_shift <= 8'h00;
                r_rx_par   <= 1'b0;
                r_rx_pe    <= 1'b0;
                r_rx_zero  <= 1'b1;
            end
        end else if (w_tick) begin
            r_rx_tcnt <= r_rx_tcnt + 4'd1;
            if (r_rx_tcnt == 4'd7) begin
                case (r_rx_state)
                    RX_START: if (w_rx_line) r_rx_state <= RX_IDLE;
                    RX_DATA: begin
                        r_rx_shift[r_rx_bcnt] <= w_rx_line;
                        r_rx_par <= r_rx_par ^ w_rx_line;
                        if (w_rx_line) r_rx_zero <= 1'b0;
                    end
                    RX_PAR: begin
                        r_rx_pe <= (w_rx_line != w_rx_exp_par);
                        if (w_rx_line) r_rx_zero <= 1'b0;
                    end
                    default: r_rx_state <= RX_IDLE;
                endcase
            end else if (r_rx_tcnt == 4'd15) begin
                case (r_rx_state)
                    RX_START: r_rx_state <= RX_DATA;
                    RX_DATA: begin
                        if (r_rx_bcnt == w_last_idx)
                            r_rx_state <= r_lcr[3] ? RX_PAR : RX_STOP;
                        else
                            r_rx_bcnt <= r_rx_bcnt + 3'd1;
                    end
                    RX_PAR:  r_rx_state <= RX_STOP;
                    default: ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart16550_regs.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart16550_regs
//  Purpose  : Self-checking bench for uart16550_regs. Register accesses come
//             from a vector table and hand-written serial sequences; read
//             expectations go through a scoreboard queue.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart16550_regs;

    logic       clk = 1'b0;
    logic       wb_rst_i = 1'b1;
    logic [2:0] wb_addr_i = 3'd0;
    logic [7:0] wb_dat_i = 8'h00;
    logic [7:0] wb_dat_o;
    logic       wb_we_i = 1'b0;
    logic       wb_re_i = 1'b0;
    logic [3:0] modem_inputs = 4'h0;
    logic       stx_pad_o;
    logic       srx_pad_i = 1'b1;
    logic       rts_pad_o, dtr_pad_o, int_o;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [7:0] value;
        string      name;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        bit         wr;
        logic [2:0] addr;
        logic [7:0] data;
        string      name;
    } vec_t;
    vec_t tbl[$];

    uart16550_regs dut (
        .clk(clk), .wb_rst_i(wb_rst_i), .wb_addr_i(wb_addr_i), .wb_dat_i(wb_dat_i),
        .wb_dat_o(wb_dat_o), .wb_we_i(wb_we_i), .wb_re_i(wb_re_i),
        .modem_inputs(modem_inputs), .stx_pad_o(stx_pad_o), .srx_pad_i(srx_pad_i),
        .rts_pad_o(rts_pad_o), .dtr_pad_o(dtr_pad_o), .int_o(int_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", nm, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        wb_addr_i = a; wb_dat_i = d; wb_we_i = 1'b1;
        @(negedge clk);
        wb_we_i = 1'b0;
    endtask

    // Push the expectation, strobe the read, pop and compare once data is out
    task automatic rd(input logic [2:0] a, input logic [7:0] e, input string nm);
        exp_t x;
        x.value = e; x.name = nm;
        sb_q.push_back(x);
        @(negedge clk);
        wb_addr_i = a; wb_re_i = 1'b1;
        @(negedge clk);
        wb_re_i = 1'b0;
        x = sb_q.pop_front();
        check(x.name, wb_dat_o, x.value);
    endtask

    task automatic add(input bit w, input logic [2:0] a, input logic [7:0] d, input string nm);
        vec_t v;
        v.wr = w; v.addr = a; v.data = d; v.name = nm;
        tbl.push_back(v);
    endtask

    // Drive one serial frame on srx_pad_i at 16 clocks per bit (divisor 1)
    task automatic send_frame(input logic [7:0] d, input int nbits, input bit use_par,
                              input bit par, input bit stp);
        srx_pad_i = 1'b0; wait_clk(16);
        for (int i = 0; i < nbits; i++) begin
            srx_pad_i = d[i]; wait_clk(16);
        end
        if (use_par) begin
            srx_pad_i = par; wait_clk(16);
        end
        srx_pad_i = stp; wait_clk(16);
        srx_pad_i = 1'b1; wait_clk(20);
    endtask

    initial begin
        logic [9:0] tx_exp;
        int k;

        // ---- reset ----
        wait_clk(3);
        check("rst_stx", {7'd0, stx_pad_o}, 8'h01);
        check("rst_int", {7'd0, int_o}, 8'h00);
        check("rst_dat_o", wb_dat_o, 8'h00);
        wb_rst_i = 1'b0;
        wait_clk(2);

        // ---- table-driven register accesses ----
        add(0, 3'd3, 8'h03, "rst_lcr");
        add(0, 3'd5, 8'h60, "rst_lsr");
        add(0, 3'd2, 8'hC1, "rst_iir");
        add(0, 3'd1, 8'h00, "rst_ier");
        add(0, 3'd4, 8'h00, "rst_mcr");
        add(0, 3'd6, 8'h00, "rst_msr");
        add(1, 3'd7, 8'hA5, "");
        add(0, 3'd7, 8'hA5, "scr_rw");
        add(1, 3'd1, 8'hF0, "");
        add(0, 3'd1, 8'h00, "ier_upper_zero");
        add(1, 3'd4, 8'hE3, "");
        add(0, 3'd4, 8'h03, "mcr_upper_zero");
        add(1, 3'd4, 8'h00, "");
        add(1, 3'd3, 8'h83, "");
        add(1, 3'd0, 8'h01, "");
        add(1, 3'd1, 8'h00, "");
        add(0, 3'd0, 8'h01, "dll_rd");
        add(0, 3'd1, 8'h00, "dlm_rd");
        add(0, 3'd3, 8'h83, "lcr_dlab_rd");
        add(1, 3'd3, 8'h03, "");
        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].wr) wr(tbl[i].addr, tbl[i].data);
            else           rd(tbl[i].addr, tbl[i].data, tbl[i].name);
        end

        // ---- modem control pins ----
        wr(3'd4, 8'h03);
        check("rts_on", {7'd0, rts_pad_o}, 8'h01);
        check("dtr_on", {7'd0, dtr_pad_o}, 8'h01);
        wr(3'd4, 8'h00);
        wait_clk(4);
        rd(3'd6, 8'h00, "msr_no_delta_outside_loop");

        // ---- transmit 0x55, 8N1, 16 clocks per bit ----
        wr(3'd0, 8'h55);
        k = 0;
        while (stx_pad_o !== 1'b0 && k < 100) begin
            @(negedge clk); k++;
        end
        check("tx_start_seen", {7'd0, stx_pad_o}, 8'h00);
        wait_clk(4);
        rd(3'd5, 8'h20, "lsr_thre_after_load");
        wait_clk(3);
        tx_exp = 10'b1010101010; // index 0 = start ... index 9 = stop
        for (int i = 0; i < 10; i++) begin
            check($sformatf("tx_bit%0d", i), {7'd0, stx_pad_o}, {7'd0, tx_exp[i]});
            if (i < 9) wait_clk(16);
        end
        wait_clk(12);
        rd(3'd5, 8'h60, "lsr_temt_after_stop");

        // ---- loopback ----
        wr(3'd4, 8'h13);
        check("loop_rts", {7'd0, rts_pad_o}, 8'h00);
        check("loop_dtr", {7'd0, dtr_pad_o}, 8'h00);
        wr(3'd0, 8'hA5);
        wait_clk(30);
        check("loop_stx_idle", {7'd0, stx_pad_o}, 8'h01);
        wait_clk(170);
        rd(3'd5, 8'h61, "loop_lsr_dr");
        wr(3'd0, 8'h3C);
        wait_clk(200);
        rd(3'd5, 8'h63, "loop_lsr_oe");
        rd(3'd5, 8'h61, "loop_lsr_oe_cleared");
        rd(3'd0, 8'h3C, "loop_rbr_overwritten");
        rd(3'd5, 8'h60, "loop_lsr_dr_cleared");
        rd(3'd6, 8'h33, "loop_msr");
        rd(3'd6, 8'h30, "loop_msr_deltas_cleared");

        // divisor 0 stops the baud; overwrite of a pending THR
        wr(3'd3, 8'h83); wr(3'd0, 8'h00); wr(3'd3, 8'h03);
        wr(3'd0, 8'h11); wr(3'd0, 8'h22);
        wait_clk(20);
        rd(3'd5, 8'h00, "div0_thr_pending");
        wr(3'd3, 8'h83); wr(3'd0, 8'h01); wr(3'd3, 8'h03);
        wait_clk(200);
        rd(3'd5, 8'h61, "div1_frame_done");
        rd(3'd0, 8'h22, "thr_overwrite_rbr");
        // FCR bit1 clears RBR and DR
        wr(3'd0, 8'h77);
        wait_clk(200);
        rd(3'd5, 8'h61, "fcr_pre_dr");
        wr(3'd2, 8'h02);
        rd(3'd5, 8'h60, "fcr_dr_cleared");
        rd(3'd0, 8'h00, "fcr_rbr_cleared");
        // FCR bit2 aborts the pending THR
        wr(3'd3, 8'h83); wr(3'd0, 8'h00); wr(3'd3, 8'h03);
        wr(3'd0, 8'h33);
        wr(3'd2, 8'h04);
        rd(3'd5, 8'h60, "fcr_thr_abort");
        wr(3'd3, 8'h83); wr(3'd0, 8'h01); wr(3'd3, 8'h03);
        wr(3'd4, 8'h00);
        wait_clk(4);
        rd(3'd6, 8'h03, "loop_exit_msr");
        rd(3'd6, 8'h00, "loop_exit_msr_cleared");

        // ---- THR empty interrupt ----
        wr(3'd1, 8'h02);
        wait_clk(1);
        check("thri_int_on", {7'd0, int_o}, 8'h01);
        rd(3'd2, 8'hC2, "iir_thri");
        wait_clk(1);
        check("thri_int_off", {7'd0, int_o}, 8'h00);
        rd(3'd2, 8'hC1, "iir_after_thri_read");
        wr(3'd1, 8'h00);

        // ---- receive errors, 8E1 ----
        wr(3'd3, 8'h1B);
        send_frame(8'h01, 8, 1'b1, 1'b0, 1'b1);
        wr(3'd1, 8'h04);
        rd(3'd2, 8'hC6, "iir_line_status");
        check("ls_int_on", {7'd0, int_o}, 8'h01);
        rd(3'd5, 8'hE5, "lsr_pe");
        rd(3'd5, 8'h61, "lsr_pe_cleared");
        rd(3'd0, 8'h01, "rbr_pe_frame");
        send_frame(8'h03, 8, 1'b1, 1'b0, 1'b0);
        rd(3'd5, 8'hE9, "lsr_fe");
        rd(3'd0, 8'h03, "rbr_fe_frame");
        send_frame(8'h00, 8, 1'b1, 1'b0, 1'b0);
        rd(3'd5, 8'hF9, "lsr_bi");
        rd(3'd0, 8'h00, "rbr_bi_frame");
        rd(3'd5, 8'h60, "lsr_clean");
        wr(3'd1, 8'h00);
        wr(3'd3, 8'h03);

        // ---- modem status ----
        wr(3'd1, 8'h08);
        modem_inputs = 4'b1000;
        wait_clk(6);
        check("ms_int_on", {7'd0, int_o}, 8'h01);
        rd(3'd2, 8'hC0, "iir_modem");
        rd(3'd6, 8'h11, "msr_dcts");
        wait_clk(1);
        check("ms_int_off", {7'd0, int_o}, 8'h00);
        rd(3'd6, 8'h10, "msr_cleared");
        modem_inputs = 4'b1010;
        wait_clk(6);
        rd(3'd6, 8'h50, "msr_ri_rise_no_teri");
        modem_inputs = 4'b1000;
        wait_clk(6);
        rd(3'd6, 8'h14, "msr_teri");
        rd(3'd6, 8'h10, "msr_teri_cleared");
        wr(3'd1, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Hard time limit so the bench can never hang
    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/uart16550_regs.md
Name: uart16550_regs

Overview:
- 16550-style UART register block and serial engine: register file, baud generator, transmitter, receiver, modem status and interrupt logic.
- Driven through a simple 8-bit register port: 3-bit address, one-cycle write and read strobes.
- Sits behind an APB adapter, which pulses strobes in the setup phase and samples read data in the access phase.
- FIFOs are reduced to single holding registers (16450-compatible depth).

Parameters:
- none

Ports:
- clk  in  1  system clock; all state on rising edge
- wb_rst_i  in  1  reset, asynchronous, active-high
- wb_addr_i  in  3  register address
- wb_dat_i  in  8  write data, valid in the cycle wb_we_i=1
- wb_dat_o  out  8  read data, registered
- wb_we_i  in  1  one-cycle write strobe
- wb_re_i  in  1  one-cycle read strobe
- modem_inputs  in  4  {cts, dsr, ri, dcd}, active-high
- stx_pad_o  out  1  serial transmit, idle high
- srx_pad_i  in  1  serial receive
- rts_pad_o  out  1  RTS, active-high
- dtr_pad_o  out  1  DTR, active-high
- int_o  out  1  interrupt, active-high

Behaviour:
- Reset: async, active-high; all state cleared except as listed below.
  - LCR=0x03; LSR=0x60; IIR=0xC1.
  - stx_pad_o=1; wb_dat_o=0; int_o=0.
  - divisor=0; baud ticks stop while divisor=0.
- Write: the register at wb_addr_i is updated at the clk edge where wb_we_i=1.
- Read: wb_dat_o is loaded at the clk edge where wb_re_i=1 and holds until the next read. Read side effects happen at that same edge.
- Register map (DLAB=LCR[7]):
  - 0: read RBR / write THR when DLAB=0; DLL when DLAB=1.
  - 1: IER[3:0] when DLAB=0 (ERBFI, ETBEI, ELSI, EDSSI; bits 7:4 read 0); DLM when DLAB=1.
  - 2: read IIR / write FCR.
    - FCR bit1 clears RBR and DR; bit2 aborts the pending THR; other bits ignored.
  - 3: LCR.
    - [1:0] word length 5..8.
    - [2] stop bits 1/2.
    - [3] parity enable; [4] even parity; [5] stick parity.
    - [6] break: forces stx_pad_o=0.
  - 4: MCR[4:0] = DTR, RTS, OUT1, OUT2, LOOP; upper bits read 0.
  - 5: LSR, read-only.
    - bits: DR, OE, PE, FE, BI, THRE, TEMT, bit7 = OR of PE/FE/BI.
    - Reading clears bits 1-4 and bit7.
  - 6: MSR = {DCD, RI, DSR, CTS, dDCD, TERI, dDSR, dCTS}.
    - Delta bits set on input change (TERI on RI falling); reading clears deltas.
  - 7: SCR, scratch read/write.
- Reading RBR clears DR.
- Baud generator:
  - 16-bit divisor {DLM,DLL}; one 16x tick every divisor clocks.
  - Writing DLL or DLM restarts the counter.
- Transmitter:
  - THR write clears THRE.
  - When the shifter is idle, it loads THR on the next tick and sets THRE.
  - Frame: start(0), data LSB first, optional parity, stop(1). Each bit lasts 16 ticks.
  - TEMT=1 only when THR and shifter are both empty.
  - THR write while THRE=0 overwrites the pending byte.
- Receiver:
  - Falling edge on the rx line starts reception.
  - Start bit rechecked at tick 8; a glitch returns the receiver to idle.
  - Data, parity and stop bits are sampled at mid-bit (tick 8).
  - At the stop bit, the byte goes to RBR and DR=1.
  - OE=1 if DR was already 1; RBR is overwritten.
  - PE set on parity mismatch; FE set if stop=0.
  - BI set if all bits incl. stop were 0.
- Loopback (MCR[4]=1):
  - stx_pad_o=1; the receiver takes the internal tx line.
  - rts_pad_o=0, dtr_pad_o=0.
  - MSR upper nibble = {OUT2, OUT1, DTR, RTS}.
- Outside loopback: rts_pad_o=MCR[1], dtr_pad_o=MCR[0].
- Interrupts, IIR[3:0] by priority:
  - 0110 line status: ELSI & LSR[4:1] != 0.
  - 0100 rx data: ERBFI & DR.
  - 0010 THR empty: ETBEI & THRE pending.
  - 0000 modem: EDSSI & any MSR delta.
  - 0001 none.
- IIR[7:4] = 1100.
- THRE interrupt pending:
  - Set on the THRE rising edge, or on an ETBEI 0->1 write while THRE=1.
  - Cleared by an IIR read reporting it, or by a THR write.
- int_o = IIR[0]==0, registered.
- Simultaneous events:
  - A new status event in the same cycle as a clearing read stays set.
  - THR write in the same cycle as a shifter load: the shifter takes the old value and THR keeps the new one.

Test Plan:
- Reset -> reads: LCR=0x03, LSR=0x60, IIR=0xC1, IER=0, MCR=0; stx_pad_o=1, int_o=0.
- LCR=0x83, DLL=1, DLM=0, LCR=0x03, THR=0x55 -> stx_pad_o shows 0,1,0,1,0,1,0,1,0,1, each 16 clocks; THRE=1 after load; TEMT=1 after stop bit.
- MCR=0x10, THR=0xA5 -> RBR reads 0xA5 and LSR DR=1; a second byte without reading RBR -> OE=1, cleared after one LSR read.
- IER=0x02 with THRE=1 -> int_o=1, IIR=0xC2; IIR read -> IIR=0xC1, int_o=0.
- LCR=0x1B (8E1), rx frame with wrong parity -> PE=1, LSR[7]=1; IER=0x04 -> IIR=0xC6.
- modem_inputs 0000->1000 -> MSR=0x11; with EDSSI=1 -> int_o=1; after MSR read -> MSR=0x10, int_o=0.
